// File: rtl/multdiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_t;

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/multdiv_signfix.sv
// Two's-complement magnitude / sign correction: passes value through, or negates it when asked.
module multdiv_signfix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? (~value + {{(WIDTH-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/multdiv_iter.sv
// Iterative radix-2 multiplier / restoring divider, one bit per cycle.
// Optional remainder output when MULTDIV_REM_EN is defined.
module multdiv_iter
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic             ctrl_SIGNED,
  output logic [WIDTH-1:0] data_result,
`ifdef MULTDIV_REM_EN
  output logic [WIDTH-1:0] data_remainder,
`endif
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy,
  output state_t           dbg_state
);

  // Handshake: a one-cycle ctrl_MULT/ctrl_DIV pulse starts (or restarts) an op; busy is high
  // until the edge leaving DONE, which also raises data_resultRDY for exactly one cycle.

  localparam int              CW      = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST    = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state;
  op_t                op;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   operand;
  logic               signed_mode, sign_a, sign_b, div_zero, div_ovf;

  logic               start, start_sa, start_sb, mult_exc;
  logic [WIDTH-1:0]   mag_a, mag_b, res_fixed;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [2*WIDTH-1:0] mul_next, div_next;

  assign start     = ctrl_MULT | ctrl_DIV;
  assign start_sa  = ctrl_SIGNED & data_operandA[WIDTH-1];
  assign start_sb  = ctrl_SIGNED & data_operandB[WIDTH-1];
  assign dbg_state = state;

  multdiv_signfix #(.WIDTH(WIDTH)) u_mag_a (.value(data_operandA), .negate(start_sa), .result(mag_a));
  multdiv_signfix #(.WIDTH(WIDTH)) u_mag_b (.value(data_operandB), .negate(start_sb), .result(mag_b));
  multdiv_signfix #(.WIDTH(WIDTH)) u_fix_res (.value(acc[WIDTH-1:0]), .negate(sign_a ^ sign_b),
                                             .result(res_fixed));

  // Multiply: upper half accumulates, lower half holds the multiplier shifting out LSB-first.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
  assign div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
  assign div_next  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  // Signed fit is judged on the magnitude: a negative product may reach 2^(W-1), a positive one not.
  always_comb begin
    mult_exc = 1'b0;
    if (!signed_mode)
      mult_exc = |acc[2*WIDTH-1:WIDTH];
    else if (sign_a ^ sign_b)
      mult_exc = (|acc[2*WIDTH-1:WIDTH]) | (acc[WIDTH-1] & (|acc[WIDTH-2:0]));
    else
      mult_exc = |acc[2*WIDTH-1:WIDTH-1];
  end

`ifdef MULTDIV_REM_EN
  logic [WIDTH-1:0] rem_fixed;
  multdiv_signfix #(.WIDTH(WIDTH)) u_fix_rem (.value(acc[2*WIDTH-1:WIDTH]), .negate(sign_a),
                                             .result(rem_fixed));
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      op             <= OP_MULT;
      count          <= '0;
      acc            <= '0;
      operand        <= '0;
      signed_mode    <= 1'b0;
      sign_a         <= 1'b0;
      sign_b         <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
`ifdef MULTDIV_REM_EN
      data_remainder <= '0;
`endif
    end else begin
      data_resultRDY <= 1'b0;
      if (start) begin
        state          <= RUN;
        op             <= ctrl_MULT ? OP_MULT : OP_DIV;
        count          <= '0;
        acc            <= {{WIDTH{1'b0}}, ctrl_MULT ? mag_b : mag_a};
        operand        <= ctrl_MULT ? mag_a : mag_b;
        signed_mode    <= ctrl_SIGNED;
        sign_a         <= start_sa;
        sign_b         <= start_sb;
        div_zero       <= ~ctrl_MULT & (data_operandB == '0);
        div_ovf        <= ~ctrl_MULT & ctrl_SIGNED & (data_operandA == MIN_VAL) & (&data_operandB);
        data_result    <= '0;
        data_exception <= 1'b0;
        busy           <= 1'b1;
`ifdef MULTDIV_REM_EN
        data_remainder <= '0;
`endif
      end else begin
        case (state)
          RUN: begin
            acc   <= (op == OP_MULT) ? mul_next : div_next;
            count <= count + 1'b1;
            if (count == LAST || div_zero)
              state <= DONE;
          end
          DONE: begin
            state          <= IDLE;
            busy           <= 1'b0;
            data_resultRDY <= 1'b1;
            if (op == OP_MULT) begin
              data_result    <= res_fixed;
              data_exception <= mult_exc;
            end else if (div_zero) begin
              data_result    <= '0;
              data_exception <= 1'b1;
            end else begin
              data_result    <= res_fixed;
              data_exception <= div_ovf;
`ifdef MULTDIV_REM_EN
              data_remainder <= rem_fixed;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/multdiv_iter.md
# multdiv_iter

Parametrised iterative multiplier/divider, next generation of the processor's multdiv unit. One shift-add or restoring-division step per cycle over a `WIDTH`-bit datapath, selectable signed/unsigned mode, explicit busy/ready handshake, asynchronous reset. Sits beside the ALU in the execute stage; the pipeline stalls while `busy` is high.

## Interface
- `WIDTH`, 32, operand/result width (≥4, even)
- `clock` in 1, rising-edge clock
- `reset` in 1, asynchronous active-high reset
- `data_operandA` in WIDTH, multiplicand / dividend, sampled only at start
- `data_operandB` in WIDTH, multiplier / divisor, sampled only at start
- `ctrl_MULT` in 1, start-multiply pulse (one cycle)
- `ctrl_DIV` in 1, start-divide pulse (one cycle)
- `ctrl_SIGNED` in 1, two's-complement mode when 1, sampled at start
- `data_result` out WIDTH, low WIDTH bits of product, or quotient
- `data_remainder` out WIDTH, remainder (present only with `MULTDIV_REM_EN`)
- `data_exception` out 1, overflow or divide-by-zero
- `data_resultRDY` out 1, one-cycle done strobe
- `busy` out 1, operation in progress

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE; all outputs 0, count 0.
- Start = `ctrl_MULT | ctrl_DIV` sampled at a rising edge. If both are high, multiply wins. Operands, op and sign mode are latched; the state goes to RUN with count = 0.
- Signed mode: operands are converted to magnitudes at start; the result sign is fixed in DONE. Quotient truncates toward zero. The remainder takes the sign of the dividend.
- MULT: radix-2 shift-add, one bit per cycle, 2·WIDTH-bit accumulator. Exception is set when the true product does not fit in WIDTH bits:
  - unsigned: upper half nonzero.
  - signed: the signed result ≠ sign-extension of the low half.
  - `data_result` = low WIDTH bits regardless.
- DIV: restoring division, one quotient bit per cycle.
  - Divisor 0: go directly RUN→DONE after one cycle, exception = 1, result = 0, remainder = 0.
  - Signed MIN / −1: exception = 1, result = MIN, remainder = 0.
- RUN→DONE when count = WIDTH−1 at an edge.
- DONE: `data_resultRDY` = 1 for exactly one cycle, then IDLE.
- `data_result`, `data_remainder` and `data_exception` hold their values until the next start is accepted; they are cleared to 0 on that start.
- Start in RUN or DONE aborts the current operation and restarts with the new operands. No `data_resultRDY` is issued for the aborted operation.

## Timing
- Start sampled at edge 0. `busy` = 1 from after edge 0 until after the edge that leaves DONE.
- Normal latency: `data_resultRDY` is high in the cycle after edge WIDTH+1, i.e. WIDTH+1 cycles after start (33 for WIDTH = 32).
- Divide-by-zero latency: 2 cycles.
- `reset` asserted mid-operation: IDLE immediately (asynchronous). Outputs go to 0 and no strobe is issued.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `MULTDIV_REM_EN` defined: the `data_remainder` port exists and is valid together with `data_resultRDY`.
- Not defined: the port is absent, and the remainder register is not kept beyond the internal datapath. Quotient and timing are identical in both builds.

## Structure
- Package `multdiv_pkg`:
  - state enum (IDLE/RUN/DONE)
  - op enum (OP_MULT/OP_DIV)
  - a counter-width function `$clog2(WIDTH)`
- Sub-module `multdiv_signfix`: combinational magnitude conversion and final sign correction, WIDTH-parametrised. It is instantiated for the operands and for the result.
- Top level holds the FSM, iteration counter, accumulator and shift registers.

## Test plan
- WIDTH=32, unsigned MULT 7×6 → RDY at cycle 33, result 42, exception 0.
- Signed MULT −3×5 → result 0xFFFFFFF1, exception 0. Then 0x40000000×4 signed → exception 1.
- Signed DIV −7/2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF (`MULTDIV_REM_EN`). Then DIV 10/0 → RDY at cycle 2, exception 1, result 0.
- Signed DIV 0x80000000 / 0xFFFFFFFF → exception 1, result 0x80000000.
- MULT start, then at cycle 10 DIV 100/7 → single RDY, 33 cycles after the DIV start, quotient 14, remainder 2. Both ctrl lines high → multiply performed.
- Reset asserted at cycle 15 of a MULT → busy, RDY, result and exception all 0 immediately. No strobe follows. A subsequent op completes normally; repeat at WIDTH=8 (RDY at cycle 9).
